// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one req/ack bus between instruction fetch and data access.
// Data accesses win over fetches; results are held until the pipeline advances.
`timescale 1ns/1ps

module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        adv,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_stall,
    input  logic        d_en,
    input  logic [3:0]  d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        bus_req,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t state;
    logic   drop;
    logic   i_done;
    logic   d_done;

    assign i_stall = ~i_done;
    assign d_stall = d_en & ~d_done;

    // Clears of the hold flags come first; a set can only happen on an ack,
    // when the flag is known to be 0, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drop      <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            bus_req   <= 1'b0;
            bus_wen   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            if (adv || flush) begin
                i_done <= 1'b0;
            end
            if (adv) begin
                d_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (d_en && !d_done) begin
                        state     <= DBUSY;
                        bus_req   <= 1'b1;
                        bus_wen   <= d_wen;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                    end else if (!i_done && !flush) begin
                        state     <= IBUSY;
                        bus_req   <= 1'b1;
                        bus_wen   <= 4'b0000;
                        bus_addr  <= i_addr;
                        bus_wdata <= '0;
                    end
                end

                // A flushed fetch still runs to its ack; only its result is thrown away.
                IBUSY: begin
                    if (bus_ack) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        drop    <= 1'b0;
                        if (!drop && !flush) begin
                            i_rdata <= bus_rdata;
                            i_done  <= 1'b1;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end

                DBUSY: begin
                    if (bus_ack) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        d_rdata <= bus_rdata;
                        d_done  <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: wait-state bus slave, transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        adv;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_en;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        bus_req;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;
    int wait_states = 0;
    int slave_cnt = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .adv       (adv),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_en      (d_en),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .bus_req   (bus_req),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slaveData(input logic [31:0] addr);
        if (addr == 32'hBFC0_0000) return 32'h3C01_0001;
        return addr ^ 32'hA5A5_0000;
    endfunction

    // Slave acks after wait_states idle cycles of an active request.
    always @(negedge clk) begin
        if (rst || !bus_req) begin
            bus_ack   = 1'b0;
            slave_cnt = 0;
        end else if (slave_cnt == wait_states) begin
            bus_ack   = 1'b1;
            bus_rdata = slaveData(bus_addr);
            slave_cnt = 0;
        end else begin
            bus_ack   = 1'b0;
            slave_cnt = slave_cnt + 1;
        end
    end

    typedef enum {NONE, FETCH, DATA} txn_kind_t;

    txn_kind_t   m_kind;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wen;
    logic [31:0] m_irdata;
    logic [31:0] m_drdata;
    bit          m_ihold;
    bit          m_dhold;
    bit          m_discard;
    bit          m_valid = 1'b0;
    bit          nx_ihold;
    bit          nx_dhold;

    // Transaction-level view: one outstanding bus transfer, two held results.
    always @(posedge clk) begin
        if (rst) begin
            m_kind    = NONE;
            m_addr    = '0;
            m_wdata   = '0;
            m_wen     = '0;
            m_irdata  = '0;
            m_drdata  = '0;
            m_ihold   = 1'b0;
            m_dhold   = 1'b0;
            m_discard = 1'b0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            nx_ihold = m_ihold && !adv && !flush;
            nx_dhold = m_dhold && !adv;
            if (m_kind == NONE) begin
                if (d_en && !m_dhold) begin
                    m_kind  = DATA;
                    m_addr  = d_addr;
                    m_wen   = d_wen;
                    m_wdata = d_wdata;
                end else if (!m_ihold && !flush) begin
                    m_kind  = FETCH;
                    m_addr  = i_addr;
                    m_wen   = '0;
                    m_wdata = '0;
                end
            end else if (bus_ack) begin
                if (m_kind == DATA) begin
                    m_drdata = bus_rdata;
                    nx_dhold = 1'b1;
                end else if (!m_discard && !flush) begin
                    m_irdata = bus_rdata;
                    nx_ihold = 1'b1;
                end
                m_discard = 1'b0;
                m_kind    = NONE;
            end else if (m_kind == FETCH && flush) begin
                m_discard = 1'b1;
            end
            m_ihold = nx_ihold;
            m_dhold = nx_dhold;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_bus_req",   {31'd0, bus_req}, {31'd0, m_kind != NONE});
            checkOutput("model_bus_addr",  bus_addr, m_addr);
            checkOutput("model_bus_wen",   {28'd0, bus_wen}, {28'd0, m_wen});
            checkOutput("model_bus_wdata", bus_wdata, m_wdata);
            checkOutput("model_i_rdata",   i_rdata, m_irdata);
            checkOutput("model_d_rdata",   d_rdata, m_drdata);
            checkOutput("model_i_stall",   {31'd0, i_stall}, {31'd0, !m_ihold});
            checkOutput("model_d_stall",   {31'd0, d_stall}, {31'd0, d_en && !m_dhold});
        end
    end

    task automatic applyStimulus(input logic fl, input logic ad, input logic de,
                                 input logic [3:0] dw, input logic [31:0] da,
                                 input logic [31:0] dd, input logic [31:0] ia);
        flush   = fl;
        adv     = ad;
        d_en    = de;
        d_wen   = dw;
        d_addr  = da;
        d_wdata = dd;
        i_addr  = ia;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;

        // Zero-wait fetch from the reset vector.
        doReset();
        wait_states = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hBFC0_0000);
        @(negedge clk);
        checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'h0);
        checkOutput("rst_i_stall", {31'd0, i_stall}, 32'd1);
        checkOutput("rst_d_stall", {31'd0, d_stall}, 32'd0);
        checkOutput("rst_i_rdata", i_rdata, 32'h0);
        checkOutput("rst_d_rdata", d_rdata, 32'h0);
        tick();
        @(negedge clk);
        checkOutput("f1_bus_req", {31'd0, bus_req}, 32'd1);
        checkOutput("f1_bus_addr", bus_addr, 32'hBFC0_0000);
        tick();
        adv = 1'b1;
        @(negedge clk);
        checkOutput("f2_i_stall", {31'd0, i_stall}, 32'd0);
        checkOutput("f2_i_rdata", i_rdata, 32'h3C01_0001);
        tick();
        adv = 1'b0;
        @(negedge clk);
        checkOutput("f3_i_stall_after_adv", {31'd0, i_stall}, 32'd1);

        // Data load and fetch both pending: data goes first.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 32'h8000_1000, 32'h0, 32'h8000_0000);
        @(negedge clk);
        checkOutput("pri0_d_stall", {31'd0, d_stall}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("pri1_bus_addr", bus_addr, 32'h8000_1000);
        checkOutput("pri1_bus_wen", {28'd0, bus_wen}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("pri2_d_stall", {31'd0, d_stall}, 32'd0);
        checkOutput("pri2_d_rdata", d_rdata, 32'h25A5_1000);
        checkOutput("pri2_bus_req", {31'd0, bus_req}, 32'd0);
        tick();
        adv  = 1'b1;
        d_en = 1'b0;
        @(negedge clk);
        checkOutput("pri3_bus_req", {31'd0, bus_req}, 32'd1);
        checkOutput("pri3_bus_addr", bus_addr, 32'h8000_0000);
        tick();
        adv = 1'b0;
        @(negedge clk);
        checkOutput("pri4_i_rdata", i_rdata, 32'h25A5_0000);
        checkOutput("pri4_i_stall", {31'd0, i_stall}, 32'd0);

        // Store through a 3-wait-state slave.
        doReset();
        wait_states = 3;
        applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 32'h8000_2000, 32'hDEAD_BEEF, 32'h8000_0000);
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            checkOutput("st_bus_req", {31'd0, bus_req}, 32'd1);
            checkOutput("st_bus_wen", {28'd0, bus_wen}, 32'h0000_000F);
            checkOutput("st_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            checkOutput("st_d_stall", {31'd0, d_stall}, 32'd1);
        end
        tick();
        @(negedge clk);
        checkOutput("st5_d_stall", {31'd0, d_stall}, 32'd0);
        checkOutput("st5_d_rdata", d_rdata, 32'h25A5_2000);
        adv  = 1'b1;
        d_en = 1'b0;
        tick();
        adv = 1'b0;
        for (int c = 0; c < 6; c++) tick();

        // Flush during a 2-wait-state fetch.
        doReset();
        wait_states = 2;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h8000_0010);
        tick();
        @(negedge clk);
        checkOutput("fl1_bus_addr", bus_addr, 32'h8000_0010);
        tick();
        flush  = 1'b1;
        i_addr = 32'h8000_0180;
        @(negedge clk);
        checkOutput("fl2_bus_req", {31'd0, bus_req}, 32'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("fl3_bus_req", {31'd0, bus_req}, 32'd1);
        checkOutput("fl3_bus_addr", bus_addr, 32'h8000_0010);
        tick();
        @(negedge clk);
        checkOutput("fl4_i_stall", {31'd0, i_stall}, 32'd1);
        checkOutput("fl4_i_rdata", i_rdata, 32'h0);
        tick();
        @(negedge clk);
        checkOutput("fl5_bus_addr", bus_addr, 32'h8000_0180);
        tick();
        tick();
        tick();
        @(negedge clk);
        checkOutput("fl8_i_rdata", i_rdata, 32'h25A5_0180);

        // Flush on the ack cycle of a fetch.
        doReset();
        wait_states = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h8000_0020);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("fa2_i_stall", {31'd0, i_stall}, 32'd1);
        checkOutput("fa2_i_rdata", i_rdata, 32'h0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("fa4_i_rdata", i_rdata, 32'h25A5_0020);

        // Flush while a data load is in flight.
        doReset();
        wait_states = 1;
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 32'h8000_3000, 32'h0, 32'h8000_0000);
        tick();
        flush = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("fd3_d_stall", {31'd0, d_stall}, 32'd0);
        checkOutput("fd3_d_rdata", d_rdata, 32'h25A5_3000);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h8000_0000);
        tick();
        adv = 1'b0;
        for (int c = 0; c < 4; c++) tick();

        // Reset while a store is in flight.
        doReset();
        wait_states = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h8000_0040);
        tick();
        tick();
        @(negedge clk);
        checkOutput("rm2_i_rdata", i_rdata, 32'h25A5_0040);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h3, 32'h8000_4000, 32'h1234_5678, 32'h8000_0040);
        wait_states = 3;
        tick();
        @(negedge clk);
        checkOutput("rm3_bus_wdata", bus_wdata, 32'h1234_5678);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_states = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hBFC0_0000);
        @(negedge clk);
        checkOutput("rm5_bus_req", {31'd0, bus_req}, 32'd0);
        checkOutput("rm5_bus_wen", {28'd0, bus_wen}, 32'd0);
        checkOutput("rm5_bus_addr", bus_addr, 32'h0);
        checkOutput("rm5_bus_wdata", bus_wdata, 32'h0);
        checkOutput("rm5_i_rdata", i_rdata, 32'h0);
        checkOutput("rm5_d_rdata", d_rdata, 32'h0);
        checkOutput("rm5_i_stall", {31'd0, i_stall}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("rm6_bus_addr", bus_addr, 32'hBFC0_0000);
        tick();
        @(negedge clk);
        checkOutput("rm7_i_rdata", i_rdata, 32'h3C01_0001);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch side (PC/IF stage) and the data side (MEM stage) of the MangoMIPS pipeline. It shares one SRAM-like bus with a req/ack handshake, gives data accesses priority, and holds each result until the pipeline consumes it. It raises `i_stall`/`d_stall` into the stall controller and handles flush by discarding in-flight fetches.

## Interface
- No parameters; address and data widths are fixed at 32 bits (`AddrBus`/`DataBus`).
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `flush` in 1 — pipeline flush. Drops any pending or held instruction result.
- `adv` in 1 — pipeline advances at this edge (`!stall`). Consumes held results.
- `i_addr` in 32 — fetch address (current PC).
- `i_rdata` out 32 — fetched instruction (registered).
- `i_stall` out 1 — fetch result not yet available.
- `d_en` in 1 — MEM stage has a load or store.
- `d_wen` in 4 — byte write enables; `0000` means load.
- `d_addr` in 32 — data address.
- `d_wdata` in 32 — store data.
- `d_rdata` out 32 — load data (registered).
- `d_stall` out 1 — data access not yet complete.
- `bus_req` out 1 — bus request.
- `bus_wen` out 4 — bus byte write enables.
- `bus_addr` out 32 — bus address.
- `bus_wdata` out 32 — bus write data.
- `bus_rdata` in 32 — bus read data; valid when `bus_ack`=1.
- `bus_ack` in 1 — one-cycle completion pulse. Ignored while `bus_req`=0.

## Operation
- FSM states: IDLE, IBUSY, DBUSY. A `drop` flag applies only in IBUSY.
- Holding flags: `i_done` and `d_done`.
- `i_stall` = `~i_done`. This is registered, with no combinational path from any input.
- `d_stall` = `d_en & ~d_done`.
- Issue decision, made in IDLE only:
  - If `d_en & ~d_done`, go to DBUSY. Latch `d_addr`, `d_wen` and `d_wdata` onto the bus registers.
  - Else if `~i_done & ~flush`, go to IBUSY. Latch `i_addr`, and set `bus_wen`=0 and `bus_wdata`=0.
  - Data has strict priority.
- `bus_req` is 1 in IBUSY and DBUSY and 0 in IDLE. The bus registers stay stable for the whole transaction.
- DBUSY with `bus_ack`:
  - Go to IDLE.
  - Set `d_done`=1.
  - Latch `d_rdata` <= `bus_rdata`, for loads and stores alike.
- IBUSY with `bus_ack`:
  - Go to IDLE.
  - If neither `drop` nor `flush` is set, latch `i_rdata` <= `bus_rdata` and set `i_done`=1.
  - Otherwise discard the result, leave `i_done` at 0, and clear `drop`.
- `flush` in IBUSY without `bus_ack` sets `drop`. The bus transaction still runs to `bus_ack`; it is never aborted.
- `flush` with `i_done`=1 clears `i_done`.
- `flush` never affects data: `d_done`, DBUSY and `d_rdata` are untouched.
- `adv`=1 clears both `i_done` and `d_done` at that edge.
- A set and a clear of the same flag in the same cycle cannot occur: set happens only on an ack cycle, clear only while the flag is already 1.
- Reset, including mid-transaction: state=IDLE, `drop`=0, and all outputs are forced to 0 at the next edge. The slave must tolerate an abandoned request.

## Timing
- Reset values:
  - `bus_req`, `bus_wen`, `bus_addr`, `bus_wdata`, `i_rdata`, `d_rdata` = 0.
  - `i_done` = `d_done` = 0, so `i_stall`=1.
  - `d_stall` follows `d_en`.
- Access timeline, with the IDLE decision in cycle 0:
  - `bus_req`=1 from cycle 1.
  - The earliest `bus_ack` is in cycle 1 (zero wait state).
  - The done flag and rdata are visible in cycle (ack+1), which is when the stall drops.
- Best-case fetch throughput is 1 instruction per 3 cycles: issue, ack, consume. The next issue happens the cycle after `adv` clears `i_done`.
- With an N-wait-state slave, each access occupies N+1 bus cycles.
- A data request arriving while IBUSY waits for that fetch's ack, then issues from IDLE on the following cycle.
- Results are held indefinitely while `adv`=0.

## Test plan
- Reset, then `i_addr`=0xBFC00000 with a zero-wait slave returning 0x3C010001:
  - `bus_req` is high in cycle 1 with `bus_addr`=0xBFC00000.
  - `i_stall` falls in cycle 2 with `i_rdata`=0x3C010001.
  - `adv`=1 in cycle 2 causes `i_stall`=1 in cycle 3.
- Simultaneous `d_en`=1 (load, 0x80001000) and a pending fetch in IDLE:
  - The data access is issued first.
  - The fetch `bus_req` begins only after `d_done`=1 and the FSM has returned to IDLE.
- Store `d_wen`=1111, `d_wdata`=0xDEADBEEF, with a 3-wait-state slave:
  - `bus_wen`/`bus_wdata` stay stable for 4 cycles.
  - `d_stall`=1 until the cycle after ack.
- `flush` asserted in the second cycle of a 2-wait-state fetch of 0x80000010:
  - `bus_req` stays high until ack.
  - The returned word is discarded and `i_stall` stays 1.
  - The next fetch uses the new `i_addr`=0x80000180.
- `flush` in the exact cycle of `bus_ack` for a fetch: the result is discarded. `flush` while DBUSY: the data completes normally with `d_done`=1.
- `rst` asserted mid-DBUSY: the next cycle has `bus_req`=0 and all outputs 0, and normal fetch resumes afterwards.
